// File: rtl/bus_xfer_pkg.sv
// Shared types and default sizing for the register bus transfer controller.
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        LATCH  = 2'd2,
        REJECT = 2'd3
    } xfer_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_IDX_W    = 3;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting index at or after last_grant+1.
module rr_arbiter
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic               grant_valid,
    output logic [GW-1:0]      grant_idx
);

    always_comb begin : p_scan
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Arbitrated src->dst register moves over the shared tri-state word bus; all strobes are flop outputs.
// Optional BUS_XFER_CHECK_EN: reject src==dst or out-of-range indices with ack+err and no strobes.
module bus_transfer_controller
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_src,
    input  logic [NUM_REQ*IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic                     busy,
    output logic [NUM_REGS-1:0]      reg_enable_out,
    output logic [NUM_REGS-1:0]      reg_enable_in
);

    localparam int GW = grant_w(NUM_REQ);

    xfer_state_t state_reg, state_next;

    logic [IDX_W-1:0]    src_reg, src_next, dst_reg, dst_next;
    logic [IDX_W-1:0]    sel_src, sel_dst;
    logic [GW-1:0]       last_grant_reg, grant_reg, grant_next;
    logic [GW-1:0]       grant_idx;
    logic                grant_valid;
    logic                take;
    logic                bad_req;
    logic [NUM_REGS-1:0] src_dec, dst_dec, out_next, in_next;
    logic [NUM_REQ-1:0]  ack_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_src = req_src[int'(grant_idx)*IDX_W +: IDX_W];
    assign sel_dst = req_dst[int'(grant_idx)*IDX_W +: IDX_W];
    assign take    = (state_reg == IDLE) && grant_valid;

    // Capture values are selected ahead of the edge so the strobes can be decoded from them.
    assign src_next   = take ? sel_src   : src_reg;
    assign dst_next   = take ? sel_dst   : dst_reg;
    assign grant_next = take ? grant_idx : grant_reg;

`ifdef BUS_XFER_CHECK_EN
    assign bad_req = (sel_src == sel_dst) || (int'(sel_src) >= NUM_REGS) ||
                     (int'(sel_dst) >= NUM_REGS);
`else
    assign bad_req = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = bad_req ? REJECT : DRIVE;
            DRIVE:   state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode only covers real registers, so an out-of-range index drives nothing.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign src_dec[gi] = (src_next == IDX_W'(gi));
        assign dst_dec[gi] = (dst_next == IDX_W'(gi));
    end

    always_comb begin
        out_next = '0;
        in_next  = '0;
        ack_next = '0;
        case (state_next)
            DRIVE: out_next = src_dec;
            LATCH: begin
                out_next             = src_dec;
                in_next              = dst_dec;
                ack_next[grant_next] = 1'b1;
            end
            REJECT:  ack_next[grant_next] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NUM_REQ - 1);
            grant_reg      <= '0;
            src_reg        <= '0;
            dst_reg        <= '0;
            reg_enable_out <= '0;
            reg_enable_in  <= '0;
            ack            <= '0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            if (take) last_grant_reg <= grant_idx;
            grant_reg      <= grant_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            reg_enable_out <= out_next;
            reg_enable_in  <= in_next;
            ack            <= ack_next;
            busy           <= (state_next != IDLE);
        end
    end

`ifdef BUS_XFER_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err <= 1'b0;
        else        err <= (state_next == REJECT);
    end
`else
    assign err = 1'b0;
`endif

    a_single_driver: assert property (@(posedge clk) disable iff (!reset) $onehot0(reg_enable_out));

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: directed table, corner sequences and random traffic vs a transfer-level model.
module tb_bus_transfer_controller;

    localparam int NR = 4;
    localparam int NG = 8;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*IW-1:0]  req_src = '0;
    logic [NR*IW-1:0]  req_dst = '0;
    logic [NR-1:0]     ack;
    logic              err;
    logic              busy;
    logic [NG-1:0]     reg_enable_out;
    logic [NG-1:0]     reg_enable_in;

    always #5 clk = ~clk;

    bus_transfer_controller #(.NUM_REQ(NR), .NUM_REGS(NG), .IDX_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_src        (req_src),
        .req_dst        (req_dst),
        .ack            (ack),
        .err            (err),
        .busy           (busy),
        .reg_enable_out (reg_enable_out),
        .reg_enable_in  (reg_enable_in)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 | 32'(i * 17 + 1);
    endfunction

    // Word registers on the bus: capture on the falling edge.
    logic [31:0] regs [NG];
    logic [31:0] exp_regs [NG];
    logic        regs_load = 1'b0;
    logic [31:0] bus;

    always_comb begin
        bus = '0;
        for (int i = 0; i < NG; i++)
            if (reg_enable_out[i]) bus = bus | regs[i];
    end

    always @(negedge clk) begin
        for (int i = 0; i < NG; i++) begin
            if (regs_load)             regs[i] <= init_val(i);
            else if (reg_enable_in[i]) regs[i] <= bus;
        end
    end

    typedef struct packed {
        logic [NG-1:0] out;
        logic [NG-1:0] inn;
        logic [NR-1:0] ack;
        logic          err;
        logic          busy;
        logic          wr;
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
        int            grant;
        logic [NG-1:0] out;
        logic [NG-1:0] inn;
        logic          err;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lg = NR - 1;
    exp_t cur = '0;
    exp_t sched[$];
    int   ack_who[$];
    int   ack_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, want, cyc);
        end
    endtask

    // Winner is the requester with the smallest rotational distance past the last grant.
    function automatic int pick(input logic [NR-1:0] r, input int last);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = NR;
        for (int i = 0; i < NR; i++) begin
            d = (i - last - 1 + 2 * NR) % NR;
            if (r[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        sched.delete();
        cur = '0;
        lg  = NR - 1;
    endtask

    task automatic step();
        exp_t          e;
        int            g;
        logic [IW-1:0] s;
        logic [IW-1:0] d;
        if (cur.wr) exp_regs[cur.dst] = exp_regs[cur.src];
        if (!cur.busy && req != '0) begin
            g  = pick(req, lg);
            lg = g;
            s  = req_src[g*IW +: IW];
            d  = req_dst[g*IW +: IW];
            e  = '0;
            e.busy = 1'b1;
`ifdef BUS_XFER_CHECK_EN
            if (s == d) begin
                e.ack = NR'(1) << g;
                e.err = 1'b1;
                sched.push_back(e);
            end else
`endif
            begin
                e.out = NG'(1) << s;
                sched.push_back(e);
                e.inn = NG'(1) << d;
                e.ack = NR'(1) << g;
                e.wr  = 1'b1;
                e.src = s;
                e.dst = d;
                sched.push_back(e);
            end
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else                  cur = '0;
        @(posedge clk);
        #1;
        cyc++;
        chk("enable_out", 32'(reg_enable_out), 32'(cur.out));
        chk("enable_in",  32'(reg_enable_in),  32'(cur.inn));
        chk("ack",        32'(ack),            32'(cur.ack));
        chk("err",        32'(err),            32'(cur.err));
        chk("busy",       32'(busy),           32'(cur.busy));
        if (ack != '0) begin
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    ack_who.push_back(i);
                    ack_cyc.push_back(cyc);
                    $display("xfer cyc=%0d req=%0d err=%0b", cyc, i, err);
                end
            end
        end
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        req       = '0;
        regs_load = 1'b1;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_enable_out", 32'(reg_enable_out), 32'h0);
        chk("rst_enable_in",  32'(reg_enable_in),  32'h0);
        chk("rst_ack",        32'(ack),            32'h0);
        chk("rst_err",        32'(err),            32'h0);
        chk("rst_busy",       32'(busy),           32'h0);
        regs_load = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < NG; i++) exp_regs[i] = init_val(i);
    endtask

    task automatic set_one(input int i, input logic [IW-1:0] s, input logic [IW-1:0] d);
        req_src[i*IW +: IW] = s;
        req_dst[i*IW +: IW] = d;
    endtask

    task automatic set_all(input logic [IW-1:0] s, input logic [IW-1:0] d);
        for (int i = 0; i < NR; i++) set_one(i, s, d);
    endtask

    initial begin
        vec_t tbl [5];
        tbl[0] = '{4'b0100, 3'd5, 3'd1, 2, 8'h20, 8'h02, 1'b0};
        tbl[1] = '{4'b0001, 3'd0, 3'd7, 0, 8'h01, 8'h80, 1'b0};
        tbl[2] = '{4'b1000, 3'd6, 3'd2, 3, 8'h40, 8'h04, 1'b0};
        tbl[3] = '{4'b0110, 3'd3, 3'd4, 1, 8'h08, 8'h10, 1'b0};
`ifdef BUS_XFER_CHECK_EN
        tbl[4] = '{4'b1001, 3'd2, 3'd2, 0, 8'h00, 8'h00, 1'b1};
`else
        tbl[4] = '{4'b1001, 3'd2, 3'd2, 0, 8'h04, 8'h04, 1'b0};
`endif

        for (int t = 0; t < 5; t++) begin
            reset_dut();
            set_all(tbl[t].src, tbl[t].dst);
            req = tbl[t].req;
            step();
            if (tbl[t].err) begin
                chk("tbl_rej_ack", 32'(ack), 32'(NR'(1) << tbl[t].grant));
                chk("tbl_rej_err", 32'(err), 32'h1);
                chk("tbl_rej_out", 32'(reg_enable_out), 32'h0);
                req = '0;
                step();
            end else begin
                chk("tbl_drive_out", 32'(reg_enable_out), 32'(tbl[t].out));
                chk("tbl_drive_in",  32'(reg_enable_in),  32'h0);
                chk("tbl_drive_ack", 32'(ack),            32'h0);
                step();
                chk("tbl_latch_out", 32'(reg_enable_out), 32'(tbl[t].out));
                chk("tbl_latch_in",  32'(reg_enable_in),  32'(tbl[t].inn));
                chk("tbl_latch_ack", 32'(ack),            32'(NR'(1) << tbl[t].grant));
                req = '0;
                step();
                step();
                chk("tbl_dst_val", regs[tbl[t].dst], init_val(int'(tbl[t].src)));
            end
        end

        // Contention: all four held high, grants rotate with one ack every 3 cycles.
        reset_dut();
        for (int i = 0; i < NR; i++) set_one(i, IW'(i + 1), IW'((i + 5) % NG));
        req = 4'b1111;
        ack_who.delete();
        ack_cyc.delete();
        repeat (15) step();
        chk("cont_count", 32'(ack_who.size()), 32'd5);
        if (ack_who.size() >= 5) begin
            chk("cont_order0", 32'(ack_who[0]), 32'd0);
            chk("cont_order1", 32'(ack_who[1]), 32'd1);
            chk("cont_order2", 32'(ack_who[2]), 32'd2);
            chk("cont_order3", 32'(ack_who[3]), 32'd3);
            chk("cont_order4", 32'(ack_who[4]), 32'd0);
            for (int k = 0; k < 4; k++)
                chk("cont_spacing", 32'(ack_cyc[k+1] - ack_cyc[k]), 32'd3);
        end
        req = '0;
        step();

        // Round-robin resume after requester 1.
        reset_dut();
        set_one(0, 3'd6, 3'd3);
        set_one(1, 3'd2, 3'd5);
        req = 4'b0010;
        step();
        step();
        chk("rr_first", 32'(ack), 32'h2);
        req = 4'b0011;
        step();
        step();
        step();
        chk("rr_resume", 32'(ack), 32'h1);
        step();
        step();
        step();
        chk("rr_next", 32'(ack), 32'h2);
        req = '0;
        step();

        // Request withdrawn during DRIVE still completes.
        reset_dut();
        set_one(0, 3'd4, 3'd6);
        req = 4'b0001;
        step();
        req = '0;
        step();
        chk("drop_ack", 32'(ack), 32'h1);
        chk("drop_in",  32'(reg_enable_in), 32'h40);
        step();
        step();
        chk("drop_dst_val", regs[6], init_val(4));

        // Asynchronous reset during DRIVE.
        reset_dut();
        set_one(2, 3'd5, 3'd1);
        set_one(0, 3'd3, 3'd6);
        req = 4'b0100;
        step();
        chk("mid_drive_out", 32'(reg_enable_out), 32'h20);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out",  32'(reg_enable_out), 32'h0);
        chk("mid_rst_in",   32'(reg_enable_in),  32'h0);
        chk("mid_rst_busy", 32'(busy),           32'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        reset = 1'b1;
        req = 4'b0101;
        step();
        step();
        chk("mid_rst_prio", 32'(ack), 32'h1);
        req = '0;
        step();
        step();
        chk("mid_rst_dst_kept", regs[1], init_val(1));
        chk("mid_rst_next_xfer", regs[6], init_val(3));

        // Random traffic against the transfer-level model.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (cur.ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_one(i, IW'($urandom_range(0, NG - 1)), IW'($urandom_range(0, NG - 1)));
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (4) step();
        for (int i = 0; i < NG; i++) chk("rand_reg_file", regs[i], exp_regs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_transfer_controller.md
# bus_transfer_controller

Sequences register-to-register moves over the shared 32-bit tri-state bus formed by the word registers. Several requesters, such as the instruction decoder and the DMA/IO path, each ask for a `src -> dst` copy. The block arbitrates among them round-robin and drives each register's `enable_out` and `enable_in` strobes so that exactly one register drives the bus at a time. Every strobe comes directly from a flop, so the tri-state enables never glitch.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `NUM_REGS`, 8: number of word registers on the bus.
- `IDX_W`, 3: register index width; must satisfy `2**IDX_W >= NUM_REGS`.

Ports:
- `clk`  in  1: single clock. State advances on the rising edge; registers capture on the falling edge.
- `reset`  in  1: asynchronous, active-low.
- `req`  in  `NUM_REQ`: level request per requester. Must be held until `ack`.
- `req_src`  in  `NUM_REQ*IDX_W`: source index, packed; requester i owns slice `[i*IDX_W +: IDX_W]`. Held stable while `req` is high.
- `req_dst`  in  `NUM_REQ*IDX_W`: destination index, packed in the same way.
- `ack`  out  `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `err`  out  1: one-cycle pulse alongside `ack` for a rejected transfer.
- `busy`  out  1: high in any state other than IDLE.
- `reg_enable_out`  out  `NUM_REGS`: one-hot-or-zero bus drive strobes.
- `reg_enable_in`  out  `NUM_REGS`: one-hot-or-zero load strobes.

## Operation
- States: IDLE, DRIVE, LATCH, REJECT.
- **IDLE**
  - All strobes are 0.
  - If any `req` is high, the arbiter grants the first requester at or after `last_grant+1`, wrapping modulo `NUM_REQ`.
  - The block latches that requester's src/dst into internal registers, updates `last_grant`, and moves to DRIVE (or to REJECT; see Configuration).
- **DRIVE**: `reg_enable_out[src]=1`, `reg_enable_in` is 0. Lets the bus settle. Always moves to LATCH.
- **LATCH**
  - `reg_enable_out[src]=1`, `reg_enable_in[dst]=1`, `ack[grant]=1`.
  - The destination register captures on the falling edge inside this cycle.
  - Always moves to IDLE.
- **REJECT**: no strobes; `ack[grant]=1`, `err=1`. Moves to IDLE.
- A requester may keep `req` high after `ack`. It is then treated as a new request, sampled in the next IDLE cycle.
- If `req` drops mid-transfer, the transfer still completes and `ack` still pulses.
- Round-robin fairness: with all requesters requesting continuously, grants rotate 0,1,2,3,0,...
- `src==dst` without checking: a legal self-reload. `enable_out` and `enable_in` are asserted on the same register.

## Timing
- Reset values:
  - state = IDLE.
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - `ack`, `err`, `busy`, and all strobes = 0.
- Reset is asynchronous. Asserting it mid-transfer clears all strobes immediately; no `ack` is issued and the destination is not written.
- Latency from `req` seen high in IDLE to `ack`:
  - 2 cycles: DRIVE, then LATCH (`ack` in the LATCH cycle).
  - 1 cycle when rejected (`ack` in the REJECT cycle).
- Throughput: one transfer every 3 cycles under continuous requests.
- `busy` is asserted from the cycle after the grant through the LATCH or REJECT cycle.
- At most one bit of `reg_enable_out` is high in any cycle; this is a bus-contention invariant checked by assertion.

## Configuration
- `BUS_XFER_CHECK_EN`
  - **Defined:** at grant, a request with `src==dst`, `src>=NUM_REGS` or `dst>=NUM_REGS` goes to REJECT. No strobes are asserted, and `ack` pulses together with `err`.
  - **Undefined:** no REJECT state and `err` is tied 0. Out-of-range indices assert no strobe, because the decode is masked to `NUM_REGS`. DRIVE and LATCH still occur and `ack` is still issued.

## Structure
- Package `bus_xfer_pkg`: the state enum typedef (IDLE, DRIVE, LATCH, REJECT) and the default parameter constants.
- Sub-module `rr_arbiter`:
  - Parameter: `NUM_REQ`.
  - Inputs: `req`, `last_grant`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Purely combinational. The controller holds `last_grant`.
- The top level contains the FSM, the src/dst/grant capture registers, and registered one-hot decode of the strobes.

## Test plan
- Single transfer: release reset; `req[2]=1`, src=5, dst=1 → `reg_enable_out=8'h20` in DRIVE; `reg_enable_out=8'h20` with `reg_enable_in=8'h02` in LATCH; `ack=4'b0100` in the 2nd cycle after grant; register 1 ends holding register 5's value.
- Contention: `req=4'b1111` held → grant order 0,1,2,3,0, one `ack` every 3 cycles, and never more than one `reg_enable_out` bit high.
- Round-robin resume: grant requester 1, then `req=4'b0011` → requester 0 is granted next, not 1.
- Reset mid-transfer: assert `reset=0` during DRIVE → all strobes 0 immediately, no `ack`, destination unchanged; after release, requester 0 has priority.
- `BUS_XFER_CHECK_EN` defined: src=3, dst=3 → `ack` together with `err=1` one cycle after grant, all strobes 0. Undefined: the same stimulus produces a self-reload with `err=0`.
- `req` dropped in DRIVE → LATCH strobes still occur and `ack` still pulses.
